// File: rtl/diferential_muxpga_pkg.sv
// Shared constants and FSM encoding for the mux fabric and its config loader.
package diferential_muxpga_pkg;

    localparam int unsigned ROWS     = 8;
    localparam int unsigned COLS     = 8;
    localparam int unsigned CFG_BITS = 4;
    localparam logic [7:0]  SYNC     = 8'hA5;

    localparam int unsigned CELLS = ROWS * COLS;
    localparam int unsigned CFG_W = CELLS * CFG_BITS;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        DATA   = 2'd1,
        CHECK  = 2'd2,
        COMMIT = 2'd3
    } state_e;

endpackage

// File: rtl/diferential_nibble_shift.sv
// Strobed MSB-first shift register that flags each completed nibble.
// o_nibble already includes the bit being strobed, so the consumer can act
// on a full nibble in the same cycle that o_nibble_done is high.
module diferential_nibble_shift #(
    parameter int unsigned WIDTH = diferential_muxpga_pkg::CFG_BITS
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_clr,
    input  logic             i_en,
    input  logic             i_sen,
    input  logic             i_sdi,
    output logic [WIDTH-1:0] o_nibble,
    output logic             o_nibble_done
);

    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic [WIDTH-1:0] r_shift;
    logic [CNT_W-1:0] r_cnt;
    logic             w_step;

    // Next shift value and completion strobe.
    always_comb begin
        w_step        = i_en && i_sen;
        o_nibble      = {r_shift[WIDTH-2:0], i_sdi};
        o_nibble_done = w_step && (r_cnt == CNT_W'(WIDTH - 1));
    end

    // Shift and bit-count state; the counter wraps so consecutive nibbles need no clear.
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_shift <= '0;
            r_cnt   <= '0;
        end else if (i_clr) begin
            r_shift <= '0;
            r_cnt   <= '0;
        end else if (w_step) begin
            r_shift <= o_nibble;
            r_cnt   <= o_nibble_done ? '0 : r_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/diferential_cfg_loader.sv
// Framed serial config loader: sync hunt, nibble assembly into a shadow
// register, XOR checksum check, and a one-cycle atomic commit to o_cfg_out.
module diferential_cfg_loader #(
    parameter int unsigned ROWS     = diferential_muxpga_pkg::ROWS,
    parameter int unsigned COLS     = diferential_muxpga_pkg::COLS,
    parameter int unsigned CFG_BITS = diferential_muxpga_pkg::CFG_BITS,
    parameter logic [7:0]  SYNC     = diferential_muxpga_pkg::SYNC
) (
    input  logic                          i_clk,
    input  logic                          i_reset,
    input  logic                          i_sdi,
    input  logic                          i_sen,
    output logic [ROWS*COLS*CFG_BITS-1:0] o_cfg_out,
    output logic                          o_cfg_loaded,
    output logic                          o_done,
    output logic                          o_err,
    output logic                          o_busy
);

    import diferential_muxpga_pkg::*;

    localparam int unsigned N_CELLS = ROWS * COLS;
    localparam int unsigned CELL_W  = $clog2(N_CELLS);
    localparam int unsigned OUT_W   = N_CELLS * CFG_BITS;

    state_e              r_state;
    state_e              w_state_next;
    logic [7:0]          r_win;
    logic [7:0]          w_win_next;
    logic [OUT_W-1:0]    r_shadow;
    logic [OUT_W-1:0]    r_cfg;
    logic [CELL_W-1:0]   r_cell;
    logic [CFG_BITS-1:0] r_xor;
    logic                r_loaded;
    logic                r_done;
    logic                r_err;

    logic [CFG_BITS-1:0] w_nibble;
    logic                w_nibble_done;
    logic                w_shift_en;
    logic                w_sync_hit;
    logic                w_bad_sum;
    logic                w_last_cell;

    diferential_nibble_shift #(
        .WIDTH(CFG_BITS)
    ) u_shift (
        .i_clk         (i_clk),
        .i_reset       (i_reset),
        .i_clr         (w_sync_hit),
        .i_en          (w_shift_en),
        .i_sen         (i_sen),
        .i_sdi         (i_sdi),
        .o_nibble      (w_nibble),
        .o_nibble_done (w_nibble_done)
    );

    // State register.
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_state <= HUNT;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode plus the sync-hit and checksum-fail strobes.
    always_comb begin
        w_state_next = r_state;
        w_win_next   = {r_win[6:0], i_sdi};
        w_shift_en   = (r_state == DATA) || (r_state == CHECK);
        w_last_cell  = (r_cell == CELL_W'(N_CELLS - 1));
        w_sync_hit   = 1'b0;
        w_bad_sum    = 1'b0;
        unique case (r_state)
            HUNT: begin
                if (i_sen && (w_win_next == SYNC)) begin
                    w_sync_hit   = 1'b1;
                    w_state_next = DATA;
                end
            end
            DATA: begin
                if (w_nibble_done && w_last_cell) begin
                    w_state_next = CHECK;
                end
            end
            CHECK: begin
                if (w_nibble_done) begin
                    if (w_nibble == r_xor) begin
                        w_state_next = COMMIT;
                    end else begin
                        w_bad_sum    = 1'b1;
                        w_state_next = HUNT;
                    end
                end
            end
            COMMIT: begin
                w_state_next = HUNT;
            end
            default: w_state_next = HUNT;
        endcase
    end

    // Datapath: sync window, shadow fill, running XOR, commit and status flags.
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_win    <= '0;
            r_shadow <= '0;
            r_cfg    <= '0;
            r_cell   <= '0;
            r_xor    <= '0;
            r_loaded <= 1'b0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_done <= (r_state == COMMIT);

            // Window only lives in HUNT; holding it at zero elsewhere forces a
            // fresh 8-bit sync after every frame or error.
            if (r_state != HUNT || w_sync_hit) begin
                r_win <= '0;
            end else if (i_sen) begin
                r_win <= w_win_next;
            end

            if (w_sync_hit) begin
                r_err  <= 1'b0;
                r_xor  <= '0;
                r_cell <= '0;
            end

            if (r_state == DATA && w_nibble_done) begin
                r_shadow[r_cell*CFG_BITS +: CFG_BITS] <= w_nibble;
                r_xor  <= r_xor ^ w_nibble;
                r_cell <= r_cell + CELL_W'(1);
            end

            if (w_bad_sum) begin
                r_err <= 1'b1;
            end

            if (r_state == COMMIT) begin
                r_cfg    <= r_shadow;
                r_loaded <= 1'b1;
            end
        end
    end

    assign o_cfg_out    = r_cfg;
    assign o_cfg_loaded = r_loaded;
    assign o_done       = r_done;
    assign o_err        = r_err;
    assign o_busy       = (r_state != HUNT);

endmodule

// File: tb/tb_diferential_cfg_loader.sv
// Directed bench for diferential_cfg_loader: a table of whole frames plus
// hand-written reset, sync-search and mid-frame-reset sequences.
module tb_diferential_cfg_loader;

    localparam int unsigned W = 256;

    logic         clk;
    logic         reset;
    logic         sdi;
    logic         sen;
    logic [W-1:0] cfg_out;
    logic         cfg_loaded;
    logic         done;
    logic         err;
    logic         busy;

    int n_vec;
    int n_miss;
    bit saw_done;

    diferential_cfg_loader dut (
        .i_clk        (clk),
        .i_reset      (reset),
        .i_sdi        (sdi),
        .i_sen        (sen),
        .o_cfg_out    (cfg_out),
        .o_cfg_loaded (cfg_loaded),
        .o_done       (done),
        .o_err        (err),
        .o_busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int         pat;
        logic [3:0] csum;
        bit         gaps;
        bit         pre;
        bit         ok;
        int         exp_pat;
        bit         exp_loaded;
    } vec_t;

    vec_t vecs[7];

    // Nibble for cell i of each test pattern.
    function automatic logic [3:0] nib(input int pat, input int i);
        case (pat)
            0:       return 4'(i % 16);
            1:       return (i % 2 == 0) ? 4'hA : 4'h5;
            2:       return 4'(15 - (i % 16));
            3:       return (i == 5) ? 4'hC : ((i == 63) ? 4'h3 : 4'h0);
            default: return 4'h0;
        endcase
    endfunction

    function automatic logic [W-1:0] build_cfg(input int pat);
        logic [W-1:0] r;
        r = '0;
        for (int i = 0; i < 64; i++) r[i*4 +: 4] = nib(pat, i);
        return r;
    endfunction

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    // One clock: drive inputs, let the edge happen, sample 1 ns later.
    task automatic tick(input logic s, input logic d);
        sen = s;
        sdi = d;
        @(posedge clk);
        #1;
        if (done) saw_done = 1'b1;
    endtask

    task automatic send_bit(input logic b, input bit gaps);
        if (gaps) tick(1'b0, 1'($urandom));
        tick(1'b1, b);
    endtask

    task automatic send_byte(input logic [7:0] v, input bit gaps);
        for (int i = 7; i >= 0; i--) send_bit(v[i], gaps);
    endtask

    task automatic send_nibbles(input int pat, input int count, input bit gaps);
        logic [3:0] n;
        for (int i = 0; i < count; i++) begin
            n = nib(pat, i);
            for (int b = 3; b >= 0; b--) send_bit(n[b], gaps);
        end
    endtask

    task automatic run_frame(input string tag, input int pat, input logic [3:0] cs,
                             input bit gaps, input bit pre, input bit ok,
                             input int exp_pat, input bit exp_loaded);
        saw_done = 1'b0;
        if (pre) begin
            // 0x5A,0x3C contains no 0xA5 window, even across the join with the sync.
            send_byte(8'h5A, gaps);
            send_byte(8'h3C, gaps);
            check({tag, ".pre_busy"}, W'(busy), W'(0));
        end
        send_byte(8'hA5, gaps);
        check({tag, ".sync_busy"}, W'(busy), W'(1));
        check({tag, ".sync_err"}, W'(err), W'(0));
        send_nibbles(pat, 64, gaps);
        for (int b = 3; b >= 0; b--) send_bit(cs[b], gaps);
        check({tag, ".last_busy"}, W'(busy), W'(ok));
        check({tag, ".last_err"}, W'(err), W'(!ok));
        check({tag, ".no_early_done"}, W'(saw_done), W'(0));
        tick(1'b0, 1'b0);
        check({tag, ".done"}, W'(done), W'(ok));
        check({tag, ".cfg"}, cfg_out, build_cfg(exp_pat));
        check({tag, ".loaded"}, W'(cfg_loaded), W'(exp_loaded));
        check({tag, ".idle_busy"}, W'(busy), W'(0));
        tick(1'b0, 1'b0);
        check({tag, ".done_drop"}, W'(done), W'(0));
    endtask

    initial begin
        logic [7:0] win;
        bit         busy_seen;
        logic       b;

        n_vec    = 0;
        n_miss   = 0;
        saw_done = 1'b0;
        reset    = 1'b0;
        sen      = 1'b0;
        sdi      = 1'b0;

        //           pat csum   gaps pre  ok  exp loaded
        vecs[0] = '{0, 4'h0, 1'b0, 1'b0, 1'b1, 0, 1'b1};  // good frame
        vecs[1] = '{0, 4'h1, 1'b0, 1'b0, 1'b0, 0, 1'b1};  // bad checksum, cfg kept
        vecs[2] = '{1, 4'h0, 1'b0, 1'b1, 1'b1, 1, 1'b1};  // preamble, A/5 data
        vecs[3] = '{0, 4'h0, 1'b1, 1'b0, 1'b1, 0, 1'b1};  // strobe gaps
        vecs[4] = '{3, 4'hF, 1'b0, 1'b0, 1'b1, 3, 1'b1};  // sparse data, C^3
        vecs[5] = '{3, 4'hE, 1'b0, 1'b0, 1'b0, 3, 1'b1};  // bad checksum
        vecs[6] = '{2, 4'h0, 1'b0, 1'b0, 1'b1, 2, 1'b1};  // descending

        // Reset held for two cycles, then released.
        @(posedge clk);
        #1;
        tick(1'b0, 1'b0);
        tick(1'b1, 1'b1);
        reset = 1'b1;
        tick(1'b0, 1'b0);
        check("rst.cfg", cfg_out, W'(0));
        check("rst.loaded", W'(cfg_loaded), W'(0));
        check("rst.done", W'(done), W'(0));
        check("rst.err", W'(err), W'(0));
        check("rst.busy", W'(busy), W'(0));

        // Random bits with any would-be 0xA5 window broken up.
        win       = 8'h00;
        busy_seen = 1'b0;
        for (int i = 0; i < 64; i++) begin
            b = 1'($urandom);
            if ({win[6:0], b} == 8'hA5) b = ~b;
            win = {win[6:0], b};
            tick(1'b1, b);
            if (busy) busy_seen = 1'b1;
        end
        check("rand.busy_never", W'(busy_seen), W'(0));
        tick(1'b0, 1'b0);

        for (int v = 0; v < 7; v++) begin
            run_frame($sformatf("vec%0d", v), vecs[v].pat, vecs[v].csum, vecs[v].gaps,
                      vecs[v].pre, vecs[v].ok, vecs[v].exp_pat, vecs[v].exp_loaded);
        end

        // Mid-frame reset after 100 data bits, with the strobe still high.
        send_byte(8'hA5, 1'b0);
        send_nibbles(2, 25, 1'b0);
        check("mid.busy_before", W'(busy), W'(1));
        reset = 1'b0;
        tick(1'b1, 1'b1);
        reset = 1'b1;
        check("mid.cfg", cfg_out, W'(0));
        check("mid.loaded", W'(cfg_loaded), W'(0));
        check("mid.busy", W'(busy), W'(0));
        check("mid.err", W'(err), W'(0));
        check("mid.done", W'(done), W'(0));
        tick(1'b0, 1'b0);
        run_frame("post_rst", 0, 4'h0, 1'b0, 1'b0, 1'b1, 0, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
